// File: rtl/serial_tx4.sv
// serial_tx4: 4-bit parallel-to-serial frame transmitter.
// Each accepted word is sent as one frame, one bit per ck cycle:
// a start bit (1), four data bits MSB first, then an optional parity bit.
// The serial line idles low. All outputs are registered, so sout never glitches.
//
// state | meaning
// ------+---------------------------------------------------------
// IDLE  | line low, ready for a word; done pulses in the first cycle
// START | start bit (1) on the line
// DATA  | data bit sreg[3-bitcnt] on the line, bitcnt counts 0..3
// PAR   | parity bit on the line (only when PARITY_EN=1)
module serial_tx4 #(
    parameter bit PARITY_EN  = 1'b1,
    parameter bit PARITY_ODD = 1'b0
) (
    input  logic       ck,
    input  logic       res,
    input  logic [3:0] din,
    input  logic       load,
    output logic       ready,
    output logic       sout,
    output logic       busy,
    output logic       done
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        PAR   = 2'd3
    } state_t;

    state_t     state;
    state_t     state_next;
    logic [1:0] bitcnt;
    logic [1:0] bitcnt_next;
    logic [1:0] bitcnt_inc;
    logic [3:0] sreg;
    logic [3:0] sreg_next;
    logic       sout_next;
    logic       busy_next;
    logic       ready_next;
    logic       done_next;
    logic       par_bit;

    // Parity over the captured word; odd parity is the complement of even.
    assign par_bit    = PARITY_ODD ? ~^sreg : ^sreg;
    assign bitcnt_inc = bitcnt + 2'd1;

    // Next-state logic; outputs are computed for the state being entered so
    // that they can be registered and line up with the state register.
    always_comb begin
        state_next  = state;
        bitcnt_next = bitcnt;
        sreg_next   = sreg;
        sout_next   = 1'b0;
        busy_next   = 1'b0;
        ready_next  = 1'b0;
        done_next   = 1'b0;
        case (state)
            IDLE: begin
                if (load && ready) begin
                    sreg_next  = din;
                    state_next = START;
                    sout_next  = 1'b1;
                    busy_next  = 1'b1;
                end else begin
                    ready_next = 1'b1;
                end
            end
            START: begin
                state_next  = DATA;
                bitcnt_next = 2'd0;
                sout_next   = sreg[3];
                busy_next   = 1'b1;
            end
            DATA: begin
                bitcnt_next = bitcnt_inc;
                if (bitcnt == 2'd3) begin
                    if (PARITY_EN) begin
                        state_next = PAR;
                        sout_next  = par_bit;
                        busy_next  = 1'b1;
                    end else begin
                        state_next = IDLE;
                        ready_next = 1'b1;
                        done_next  = 1'b1;
                    end
                end else begin
                    sout_next = sreg[2'd3 - bitcnt_inc];
                    busy_next = 1'b1;
                end
            end
            PAR: begin
                state_next = IDLE;
                ready_next = 1'b1;
                done_next  = 1'b1;
            end
            default: begin
                state_next = IDLE;
                ready_next = 1'b1;
            end
        endcase
    end

    // State and output registers; reset wins over any load on the same edge.
    always_ff @(posedge ck) begin
        if (res) begin
            state  <= IDLE;
            bitcnt <= 2'd0;
            sreg   <= 4'd0;
            sout   <= 1'b0;
            busy   <= 1'b0;
            ready  <= 1'b1;
            done   <= 1'b0;
        end else begin
            state  <= state_next;
            bitcnt <= bitcnt_next;
            sreg   <= sreg_next;
            sout   <= sout_next;
            busy   <= busy_next;
            ready  <= ready_next;
            done   <= done_next;
        end
    end

endmodule

// File: tb/tb_serial_tx4.sv
// Testbench for serial_tx4: three instances (even parity, odd parity, no parity)
// share one stimulus stream. A frame-level reference model turns every accepted
// word into a list of line bits; expected {sout,ready,busy,done} per cycle go into
// a queue per instance, and a monitor pops and compares after every rising edge.
module tb_serial_tx4;

    logic       ck;
    logic       res;
    logic       load;
    logic [3:0] din;
    logic [2:0] sout_v;
    logic [2:0] ready_v;
    logic [2:0] busy_v;
    logic [2:0] done_v;

    int errors = 0;
    int checks = 0;

    bit       cfg_pe [3] = '{1'b1, 1'b1, 1'b0};
    bit       cfg_po [3] = '{1'b0, 1'b1, 1'b0};
    bit       line_q [3][$];
    bit       last_f [3];
    bit       rdy_m  [3];
    logic [3:0] exp_q [3][$];
    int       cyc = 0;

    serial_tx4 #(.PARITY_EN(1'b1), .PARITY_ODD(1'b0)) u_even (
        .ck(ck), .res(res), .din(din), .load(load),
        .ready(ready_v[0]), .sout(sout_v[0]), .busy(busy_v[0]), .done(done_v[0])
    );
    serial_tx4 #(.PARITY_EN(1'b1), .PARITY_ODD(1'b1)) u_odd (
        .ck(ck), .res(res), .din(din), .load(load),
        .ready(ready_v[1]), .sout(sout_v[1]), .busy(busy_v[1]), .done(done_v[1])
    );
    serial_tx4 #(.PARITY_EN(1'b0), .PARITY_ODD(1'b0)) u_nopar (
        .ck(ck), .res(res), .din(din), .load(load),
        .ready(ready_v[2]), .sout(sout_v[2]), .busy(busy_v[2]), .done(done_v[2])
    );

    initial ck = 1'b0;
    always #5 ck = ~ck;

    // Drive one edge's inputs (called at a falling edge) and predict the outputs
    // each instance shows after that edge.
    task automatic step(input bit r, input bit ld, input logic [3:0] d);
        logic [3:0] e;
        int         ones;
        res  = r;
        load = ld;
        din  = d;
        for (int i = 0; i < 3; i++) begin
            if (r) begin
                line_q[i].delete();
                last_f[i] = 1'b0;
                e = 4'b0100;
            end else if (line_q[i].size() > 0) begin
                e = {line_q[i].pop_front(), 3'b010};
                if (line_q[i].size() == 0) last_f[i] = 1'b1;
            end else if (last_f[i]) begin
                e = 4'b0101;
                last_f[i] = 1'b0;
            end else if (ld && rdy_m[i]) begin
                e = 4'b1010;
                ones = 0;
                for (int k = 3; k >= 0; k--) begin
                    line_q[i].push_back(d[k]);
                    ones += int'(d[k]);
                end
                if (cfg_pe[i])
                    line_q[i].push_back(cfg_po[i] ? ((ones % 2) == 0) : ((ones % 2) == 1));
            end else begin
                e = 4'b0100;
            end
            rdy_m[i] = e[2];
            exp_q[i].push_back(e);
        end
        @(negedge ck);
    endtask

    task automatic idle(input int n);
        for (int j = 0; j < n; j++) step(1'b0, 1'b0, 4'd0);
    endtask

    // Scoreboard monitor: one expected entry per instance per edge.
    initial begin
        logic [3:0] e;
        logic [3:0] a;
        forever begin
            @(posedge ck);
            #1;
            cyc++;
            for (int i = 0; i < 3; i++) begin
                if (exp_q[i].size() > 0) begin
                    e = exp_q[i].pop_front();
                    a = {sout_v[i], ready_v[i], busy_v[i], done_v[i]};
                    checks++;
                    if (a !== e) begin
                        errors++;
                        $display("FAIL outputs inst=%0d cyc=%0d {sout,ready,busy,done} got=%b want=%b",
                                 i, cyc, a, e);
                    end
                end
            end
        end
    end

    initial begin
        res  = 1'b0;
        load = 1'b0;
        din  = 4'd0;
        for (int i = 0; i < 3; i++) begin
            rdy_m[i]  = 1'b0;
            last_f[i] = 1'b0;
        end
        @(negedge ck);

        // reset with load and all-ones word: nothing must start
        step(1'b1, 1'b1, 4'b1111);
        idle(3);

        // single frames: 1011, then 0000
        step(1'b0, 1'b1, 4'b1011);
        idle(8);
        step(1'b0, 1'b1, 4'b0000);
        idle(8);

        // load during a frame is ignored
        step(1'b0, 1'b1, 4'b1011);
        idle(1);
        step(1'b0, 1'b1, 4'b0110);
        idle(8);

        // back-to-back with load held high
        for (int j = 0; j < 7; j++) step(1'b0, 1'b1, 4'b1001);
        for (int j = 0; j < 7; j++) step(1'b0, 1'b1, 4'b0101);
        idle(9);

        // abort mid-frame, then restart
        step(1'b0, 1'b1, 4'b1011);
        idle(2);
        step(1'b1, 1'b0, 4'd0);
        idle(1);
        step(1'b0, 1'b1, 4'b1101);
        idle(8);

        // random traffic
        for (int j = 0; j < 400; j++)
            step($urandom_range(0, 59) == 0, $urandom_range(0, 2) == 0, 4'($urandom_range(0, 15)));
        idle(8);

        // let the monitor drain its queues
        for (int t = 0; t < 10; t++) begin
            if (exp_q[0].size() == 0 && exp_q[1].size() == 0 && exp_q[2].size() == 0) break;
            @(posedge ck);
        end
        @(posedge ck);
        #2;
        checks++;
        if (exp_q[0].size() + exp_q[1].size() + exp_q[2].size() != 0) begin
            errors++;
            $display("FAIL drain pending=%0d want=0",
                     exp_q[0].size() + exp_q[1].size() + exp_q[2].size());
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
